imem_arbiter: RTL and testbench

//  Shares the single-ported 8K x 32 instruction memory between two requesters.
//  - Fetch stage: reads, high priority.
//  - Program loader: writes, low priority, with a starvation guard.

---
 rtl/imem_arbiter.sv | 139 +++++++++++++
 tb/tb_imem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : imem_arbiter
// Purpose  : Shares the single-ported instruction memory between fetch reads
//            (high priority) and loader writes (low priority, starvation guard).
// Revision : 1.0 - initial release
// ============================================================================
module imem_arbiter #(
    parameter int ADDR_W       = 13,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              pulse_en,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_gnt,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_gnt,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int                CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0]  LIMIT_C = CNT_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              fetch_gnt_q;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic              ld_gnt_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              busy_q;

    logic starved_d;
    logic grant_rd_d;
    logic grant_wr_d;

    // A saturated counter with the loader still waiting hands it the next slot.
    assign starved_d  = ld_req && (starve_cnt_q == LIMIT_C);
    assign grant_rd_d = fetch_req && !starved_d;
    assign grant_wr_d = ld_req && !grant_rd_d;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q       <= IDLE;
            starve_cnt_q  <= '0;
            fetch_gnt_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            ld_gnt_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            busy_q        <= 1'b0;
        end else begin
            // Strobes last one clk regardless of pulse_en.
            fetch_gnt_q   <= 1'b0;
            fetch_valid_q <= 1'b0;
            ld_gnt_q      <= 1'b0;
            mem_en_q      <= 1'b0;
            if (pulse_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (grant_rd_d) begin
                            state_q     <= RD;
                            busy_q      <= 1'b1;
                            fetch_gnt_q <= 1'b1;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= 1'b0;
                            mem_addr_q  <= fetch_addr;
                        end else if (grant_wr_d) begin
                            state_q     <= WR;
                            busy_q      <= 1'b1;
                            ld_gnt_q    <= 1'b1;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= ld_addr;
                            mem_wdata_q <= ld_wdata;
                        end
                        if (grant_rd_d && ld_req) begin
                            if (starve_cnt_q != LIMIT_C) begin
                                starve_cnt_q <= starve_cnt_q + 1'b1;
                            end
                        end else begin
                            starve_cnt_q <= '0;
                        end
                    end
                    RD: begin
                        fetch_data_q  <= mem_rdata;
                        fetch_valid_q <= 1'b1;
                        state_q       <= IDLE;
                        busy_q        <= 1'b0;
                    end
                    WR: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign fetch_gnt   = fetch_gnt_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign ld_gnt      = ld_gnt_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_imem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_arbiter
// Purpose  : Directed self-checking bench for imem_arbiter with a sync-read
//            memory model; pulse_en steps at most every other clk.
// Revision : 1.0 - initial release
// ============================================================================
module tb_imem_arbiter;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;

    logic              clk;
    logic              clr_n;
    logic              pulse_en;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_wdata;
    logic              ld_gnt;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .pulse_en   (pulse_en),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_gnt  (fetch_gnt),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .ld_req     (ld_req),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_gnt     (ld_gnt),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sync-read memory; unwritten words return a fixed pattern.
    logic [DATA_W-1:0] mem [0:8191];
    bit                written [0:8191];
    int                wr_cnt = 0;

    function automatic logic [DATA_W-1:0] default_word(input logic [ADDR_W-1:0] a);
        if (a == 13'h0010) return 32'h8C22_0004;
        return 32'hA5A5_0000 | {19'h0, a};
    endfunction

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                mem[mem_addr]     <= mem_wdata;
                written[mem_addr] <= 1'b1;
                wr_cnt            <= wr_cnt + 1;
            end else begin
                mem_rdata <= written[mem_addr] ? mem[mem_addr] : default_word(mem_addr);
            end
        end
    end

    // Pulse monitors; each strobe is high for exactly one clk.
    int  fv_cnt = 0;
    int  fg_cnt = 0;
    int  lg_cnt = 0;
    byte seq[$];

    always @(negedge clk) begin
        if (fetch_valid) fv_cnt++;
        if (fetch_gnt) begin
            fg_cnt++;
            seq.push_back("F");
        end
        if (ld_gnt) begin
            lg_cnt++;
            seq.push_back("L");
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step_on();
        @(negedge clk);
        pulse_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step_off(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pulse_en = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic one_access();
        step_on();
        step_off(1);
        step_on();
        step_off(1);
    endtask

    int    fv0;
    int    lg0;
    int    wr0;
    string exp_seq;

    initial begin
        clr_n      = 1'b0;
        pulse_en   = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        ld_req     = 1'b0;
        ld_addr    = '0;
        ld_wdata   = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_fetch_gnt", fetch_gnt, 0);
        check("rst_fetch_data", fetch_data, 0);
        @(negedge clk);
        clr_n = 1'b1;

        // 1. Reset while a read is in flight
        fetch_req  = 1'b1;
        fetch_addr = 13'h0040;
        step_on();
        check("t1_gnt", fetch_gnt, 1);
        check("t1_addr", mem_addr, 32'h40);
        fetch_req = 1'b0;
        #2;
        clr_n = 1'b0;
        #1;
        check("t1_async_busy", busy, 0);
        check("t1_async_mem_en", mem_en, 0);
        @(negedge clk);
        clr_n = 1'b1;
        one_access();
        check("t1_no_valid", fv_cnt, 0);
        check("t1_busy", busy, 0);
        check("t1_mem_addr", mem_addr, 0);
        check("t1_fetch_data", fetch_data, 0);

        // 2. Basic fetch
        fetch_req  = 1'b1;
        fetch_addr = 13'h0010;
        step_on();
        check("t2_gnt", fetch_gnt, 1);
        check("t2_mem_en", mem_en, 1);
        check("t2_mem_we", mem_we, 0);
        check("t2_mem_addr", mem_addr, 32'h10);
        check("t2_busy", busy, 1);
        fetch_req = 1'b0;
        step_off(1);
        check("t2_gnt_clr", fetch_gnt, 0);
        check("t2_en_clr", mem_en, 0);
        step_on();
        check("t2_valid", fetch_valid, 1);
        check("t2_data", fetch_data, 32'h8C22_0004);
        check("t2_idle", busy, 0);
        step_off(1);
        check("t2_valid_clr", fetch_valid, 0);
        check("t2_data_hold", fetch_data, 32'h8C22_0004);

        // 3. Loader write at the top address, then read it back
        ld_req   = 1'b1;
        ld_addr  = 13'h1FFF;
        ld_wdata = 32'hDEAD_BEEF;
        step_on();
        check("t3_ld_gnt", ld_gnt, 1);
        check("t3_mem_en", mem_en, 1);
        check("t3_mem_we", mem_we, 1);
        check("t3_mem_addr", mem_addr, 32'h1FFF);
        check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        ld_req = 1'b0;
        step_off(1);
        step_on();
        check("t3_wr_done", busy, 0);
        check("t3_no_valid", fetch_valid, 0);
        step_off(1);
        fetch_req  = 1'b1;
        fetch_addr = 13'h1FFF;
        step_on();
        fetch_req = 1'b0;
        step_off(1);
        step_on();
        check("t3_rb_valid", fetch_valid, 1);
        check("t3_rb_data", fetch_data, 32'hDEAD_BEEF);
        check("t3_wdata_hold", mem_wdata, 32'hDEAD_BEEF);
        step_off(1);

        // 4. Both requesters held: four fetches then one load, repeating
        seq.delete();
        fetch_req  = 1'b1;
        fetch_addr = 13'h0020;
        ld_req     = 1'b1;
        ld_addr    = 13'h0100;
        ld_wdata   = 32'h1234_5678;
        for (int i = 0; i < 10; i++) one_access();
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        exp_seq   = "FFFFLFFFFL";
        check("t4_len", seq.size(), 10);
        for (int i = 0; i < 10 && i < seq.size(); i++)
            check($sformatf("t4_seq%0d", i), seq[i], exp_seq[i]);

        // 5. pulse_en low for 3 clks while in RD
        fetch_req  = 1'b1;
        fetch_addr = 13'h0010;
        step_on();
        check("t5_gnt", fetch_gnt, 1);
        fetch_req = 1'b0;
        fv0 = fv_cnt;
        step_off(3);
        check("t5_hold_busy", busy, 1);
        check("t5_hold_novalid", fv_cnt, fv0);
        step_on();
        check("t5_valid", fetch_valid, 1);
        check("t5_data", fetch_data, 32'h8C22_0004);
        step_off(2);
        check("t5_single", fv_cnt, fv0 + 1);

        // 6. Loader drops its request before being served
        seq.delete();
        lg0        = lg_cnt;
        wr0        = wr_cnt;
        fetch_req  = 1'b1;
        fetch_addr = 13'h0030;
        ld_req     = 1'b1;
        ld_addr    = 13'h0200;
        ld_wdata   = 32'hCAFE_F00D;
        one_access();
        step_on();
        ld_req = 1'b0;
        step_off(1);
        step_on();
        step_off(1);
        one_access();
        check("t6_no_ld_gnt", lg_cnt, lg0);
        check("t6_no_write", wr_cnt, wr0);
        ld_req = 1'b1;
        for (int i = 0; i < 5; i++) one_access();
        fetch_req = 1'b0;
        ld_req    = 1'b0;
        exp_seq   = "FFFFFFFL";
        check("t6_len", seq.size(), 8);
        for (int i = 0; i < 8 && i < seq.size(); i++)
            check($sformatf("t6_seq%0d", i), seq[i], exp_seq[i]);
        check("t6_ld_gnt", lg_cnt, lg0 + 1);
        check("t6_write", wr_cnt, wr0 + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
